// File: rtl/ringosc_freq_meter.sv
// ============================================================================
//  Module   : ringosc_freq_meter
//  Brief    : Gated rising-edge counter for one selected ring-oscillator tap.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ringosc_freq_meter #(
   parameter int NUM_TAPS    = 14,
   parameter int COUNT_WIDTH = 24,
   parameter int SYNC_STAGES = 2,
   parameter int MAX_LOG2    = 20
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_TAPS-1:0]    tap_in,
   input  logic [3:0]             tap_sel,
   input  logic [4:0]             gate_log2,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic [COUNT_WIDTH-1:0] count,
   output logic                   overflow,
   input  logic [1:0]             byte_sel,
   output logic [7:0]             byte_out
);

   localparam int c_GW = MAX_LOG2 + 1;

   localparam logic [1:0] c_IDLE    = 2'd0;
   localparam logic [1:0] c_SETTLE  = 2'd1;
   localparam logic [1:0] c_GATE    = 2'd2;
   localparam logic [1:0] c_PUBLISH = 2'd3;

   logic [1:0]             r_state;
   logic [3:0]             r_sel;
   logic [c_GW-1:0]        r_gate_cnt;
   logic [c_GW-1:0]        r_gate_last;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic [COUNT_WIDTH-1:0] r_edge;
   logic                   r_ovf_int;
   logic [COUNT_WIDTH-1:0] r_count;
   logic                   r_overflow;

   logic                   w_tap;
   logic                   w_rise;
   logic                   w_edge_full;
   logic [4:0]             w_g;
   logic [COUNT_WIDTH-1:0] w_edge_next;
   logic                   w_ovf_next;
   logic [31:0]            w_count_ext;

   // Out-of-range selects fall through to the constant 0 default.
   always_comb begin
      w_tap = 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
         if (r_sel == 4'(i)) begin
            w_tap = tap_in[i];
         end
      end
   end

   assign w_g         = (32'(gate_log2) > 32'(MAX_LOG2)) ? 5'(MAX_LOG2) : gate_log2;
   assign w_rise      = r_sync[SYNC_STAGES-1] & ~r_prev;
   assign w_edge_full = &r_edge;
   assign w_edge_next = (w_rise && !w_edge_full) ? r_edge + 1'b1 : r_edge;
   assign w_ovf_next  = r_ovf_int | (w_rise & w_edge_full);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= c_IDLE;
         r_sel       <= 4'd0;
         r_gate_cnt  <= '0;
         r_gate_last <= '0;
         r_sync      <= '0;
         r_prev      <= 1'b0;
         r_edge      <= '0;
         r_ovf_int   <= 1'b0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], w_tap};
         r_prev <= r_sync[SYNC_STAGES-1];
         case (r_state)
            c_IDLE: begin
               if (start) begin
                  r_sel       <= tap_sel;
                  r_gate_last <= (c_GW'(1) << w_g) - c_GW'(1);
                  r_gate_cnt  <= '0;
                  r_edge      <= '0;
                  r_ovf_int   <= 1'b0;
                  r_state     <= c_SETTLE;
               end
            end
            // SYNC_STAGES+1 cycles: flush the chain plus the previous-value flop.
            c_SETTLE: begin
               if (r_gate_cnt == c_GW'(SYNC_STAGES)) begin
                  r_gate_cnt <= '0;
                  r_state    <= c_GATE;
               end else begin
                  r_gate_cnt <= r_gate_cnt + 1'b1;
               end
            end
            // Result is loaded on the last gate edge so count is valid alongside done.
            c_GATE: begin
               r_edge    <= w_edge_next;
               r_ovf_int <= w_ovf_next;
               if (r_gate_cnt == r_gate_last) begin
                  r_count    <= w_edge_next;
                  r_overflow <= w_ovf_next;
                  r_state    <= c_PUBLISH;
               end else begin
                  r_gate_cnt <= r_gate_cnt + 1'b1;
               end
            end
            c_PUBLISH: begin
               r_state <= c_IDLE;
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   assign busy        = (r_state == c_SETTLE) || (r_state == c_GATE);
   assign done        = (r_state == c_PUBLISH);
   assign count       = r_count;
   assign overflow    = r_overflow;
   assign w_count_ext = 32'(r_count);
   assign byte_out    = w_count_ext[{byte_sel, 3'b000} +: 8];

endmodule

`default_nettype wire

// File: tb/tb_ringosc_freq_meter.sv
// Bench for ringosc_freq_meter: wide instance (a) and 4-bit saturating instance (b)
// share all inputs; expected results are queued per instance and popped on done.
`default_nettype none

module tb_ringosc_freq_meter;

   typedef struct {
      int unsigned cnt;
      bit          ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [13:0] tap_in;
   logic [3:0]  tap_sel;
   logic [4:0]  gate_log2;
   logic        start;
   logic [1:0]  byte_sel;

   logic        busy_a, done_a, overflow_a;
   logic [23:0] count_a;
   logic [7:0]  byte_out_a;
   logic        busy_b, done_b, overflow_b;
   logic [3:0]  count_b;
   logic [7:0]  byte_out_b;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   dones_a = 0;
   int   last_done_a = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   int   tap_per[14];
   bit   tap_lvl[14];

   ringosc_freq_meter #(.NUM_TAPS(14), .COUNT_WIDTH(24), .SYNC_STAGES(2), .MAX_LOG2(10)) dut_a (
      .clk(clk), .rst_n(rst_n), .tap_in(tap_in), .tap_sel(tap_sel), .gate_log2(gate_log2),
      .start(start), .busy(busy_a), .done(done_a), .count(count_a), .overflow(overflow_a),
      .byte_sel(byte_sel), .byte_out(byte_out_a));

   ringosc_freq_meter #(.NUM_TAPS(14), .COUNT_WIDTH(4), .SYNC_STAGES(2), .MAX_LOG2(10)) dut_b (
      .clk(clk), .rst_n(rst_n), .tap_in(tap_in), .tap_sel(tap_sel), .gate_log2(gate_log2),
      .start(start), .busy(busy_b), .done(done_b), .count(count_b), .overflow(overflow_b),
      .byte_sel(byte_sel), .byte_out(byte_out_b));

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Tap patterns: period 0 means constant level, else square wave of that period.
   initial begin
      tap_in = '0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 14; i++) begin
            if (tap_per[i] == 0) tap_in[i] = tap_lvl[i];
            else                 tap_in[i] = ((cyc % tap_per[i]) < (tap_per[i] / 2));
         end
      end
   end

   initial begin : mon_a
      bit   prev = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (done_a) begin
            checks++;
            if (prev) begin
               errors++;
               $display("FAIL a_done_width done high two cycles in a row");
            end else if (q_a.size() == 0) begin
               errors++;
               $display("FAIL a_unexpected_done count=%0d ovf=%0b expected no done", count_a, overflow_a);
            end else begin
               e = q_a.pop_front();
               if (count_a !== 24'(e.cnt) || overflow_a !== e.ovf) begin
                  errors++;
                  $display("FAIL a_result count=%0d ovf=%0b expected count=%0d ovf=%0b",
                           count_a, overflow_a, e.cnt, e.ovf);
               end
            end
            dones_a++;
            last_done_a = cyc;
         end
         prev = done_a;
      end
   end

   initial begin : mon_b
      exp_t e;
      forever begin
         @(negedge clk);
         if (done_b) begin
            checks++;
            if (q_b.size() == 0) begin
               errors++;
               $display("FAIL b_unexpected_done count=%0d ovf=%0b expected no done", count_b, overflow_b);
            end else begin
               e = q_b.pop_front();
               if (count_b !== 4'(e.cnt) || overflow_b !== e.ovf) begin
                  errors++;
                  $display("FAIL b_result count=%0d ovf=%0b expected count=%0d ovf=%0b",
                           count_b, overflow_b, e.cnt, e.ovf);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic expect_run(input int ca, input bit oa, input int cb, input bit ob);
      exp_t e;
      e.cnt = ca; e.ovf = oa; q_a.push_back(e);
      e.cnt = cb; e.ovf = ob; q_b.push_back(e);
   endtask

   // Returns at the negedge of cycle 1 (start sampled at the end of cycle 0).
   task automatic launch(input logic [3:0] sel, input logic [4:0] g);
      @(negedge clk);
      tap_sel   = sel;
      gate_log2 = g;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int d0 = dones_a;
      int i  = 0;
      while (i < budget && dones_a == d0) begin
         @(negedge clk);
         #1;
         i++;
      end
      if (dones_a == d0) begin
         checks++;
         errors++;
         $display("FAIL wait_done timeout after %0d cycles expected a done", budget);
      end
   endtask

   initial begin
      int bad_k;
      int d1;
      for (int i = 0; i < 14; i++) begin
         tap_per[i] = 0;
         tap_lvl[i] = 1'b0;
      end
      rst_n = 1'b0; start = 1'b0; tap_sel = 4'd0; gate_log2 = 5'd0; byte_sel = 2'd0;

      @(posedge clk);
      #1;
      chk("reset_busy", busy_a, 0);
      chk("reset_done", done_a, 0);
      chk("reset_count", count_a, 0);
      chk("reset_ovf", overflow_a, 0);
      chk("reset_byte", byte_out_a, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Period 8 on tap 3, 64-cycle window: 8 edges, done in cycle 68.
      tap_per[3] = 8;
      repeat (20) @(negedge clk);
      expect_run(8, 0, 8, 0);
      launch(4'd3, 5'd6);
      bad_k = -1;
      for (int k = 1; k <= 70; k++) begin
         if (bad_k < 0 && (busy_a !== (k <= 67) || done_a !== (k == 68))) bad_k = k;
         @(negedge clk);
      end
      chk("busy_done_timing_first_bad_cycle", bad_k, -1);

      // Constant-high tap: no edges; previous result held until done.
      tap_per[3] = 0; tap_lvl[3] = 1'b1;
      expect_run(0, 0, 0, 0);
      launch(4'd3, 5'd6);
      repeat (10) @(negedge clk);
      chk("hold_prev_count", count_a, 8);
      wait_done(200);

      // Select beyond NUM_TAPS reads constant 0 even with active taps.
      tap_per[3] = 6;
      tap_per[13] = 2;
      repeat (10) @(negedge clk);
      expect_run(0, 0, 0, 0);
      launch(4'd15, 5'd6);
      wait_done(200);

      // Every-other-cycle edges: 32 attempted; 4-bit instance saturates.
      tap_per[3] = 2;
      repeat (10) @(negedge clk);
      expect_run(32, 0, 15, 1);
      launch(4'd3, 5'd6);
      wait_done(200);
      tap_per[3] = 0; tap_lvl[3] = 1'b0;
      expect_run(0, 0, 0, 0);
      launch(4'd3, 5'd6);
      wait_done(200);

      // gate_log2=31 clamps to 10: 1024-cycle window, period 4 gives 256.
      tap_per[3] = 4;
      repeat (10) @(negedge clk);
      expect_run(256, 0, 15, 1);
      launch(4'd3, 5'd31);
      wait_done(1300);
      for (int s = 0; s < 4; s++) begin
         byte_sel = 2'(s);
         #1;
         chk($sformatf("a_byte%0d", s), byte_out_a, (s == 1) ? 1 : 0);
         chk($sformatf("b_byte%0d", s), byte_out_b, (s == 0) ? 15 : 0);
      end
      byte_sel = 2'd0;

      // Mid-run start pulse with new select/exponent must not disturb the run.
      tap_per[3] = 8;
      tap_per[5] = 2;
      repeat (10) @(negedge clk);
      expect_run(8, 0, 8, 0);
      launch(4'd3, 5'd6);
      repeat (20) @(negedge clk);
      tap_sel = 4'd5; gate_log2 = 5'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(200);

      // start held high: back-to-back runs, dones 69 cycles apart.
      expect_run(8, 0, 8, 0);
      expect_run(8, 0, 8, 0);
      @(negedge clk);
      tap_sel = 4'd3; gate_log2 = 5'd6; start = 1'b1;
      wait_done(200);
      d1 = last_done_a;
      wait_done(200);
      start = 1'b0;
      chk("back_to_back_interval", last_done_a - d1, 69);

      // Reset mid-GATE: outputs clear immediately and the run never completes.
      launch(4'd3, 5'd6);
      repeat (20) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy_a, 0);
      chk("midrst_done", done_a, 0);
      chk("midrst_count", count_a, 0);
      chk("midrst_ovf", overflow_a, 0);
      chk("midrst_byte", byte_out_a, 0);
      chk("midrst_count_b", count_b, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (150) @(negedge clk);
      chk("post_reset_busy", busy_a, 0);
      chk("pending_a", q_a.size(), 0);
      chk("pending_b", q_b.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
